// File: rtl/sram_port_arbiter_pkg.sv
// Shared types for the instruction/data memory port arbiter.
// Owner IDs, lock-FSM states and access-size encodings.
package sram_port_arbiter_pkg;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_I = 2'd1,
    HOLD_D = 2'd2
  } lock_state_t;

endpackage

// File: rtl/sram_port_arbiter_owner_fifo.sv
// In-order owner FIFO: one bit per in-flight transaction.
// Push and pop may both occur in one cycle.
module owner_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic dout,
  output logic full,
  output logic empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic          mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wrap_inc(wr_ptr);
      if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one split-handshake memory port between fetch and data.
// Data wins by default; a starved fetch is forced through.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int STARVE_LIMIT    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        err_resp
);

  lock_state_t state;
  lock_state_t state_nxt;
  logic        sel;
  logic        sel_req;
  logic        force_i;
  logic        accept;
  logic        resp;
  logic        pop;
  logic        head;
  logic        full;
  logic        empty;
  logic [3:0]  starve_cnt;

  assign force_i = (starve_cnt == 4'(STARVE_LIMIT));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (mem_req && !mem_addr_ok)
          state_nxt = (sel == OWN_DATA) ? HOLD_D : HOLD_I;
      HOLD_I, HOLD_D:
        if (mem_addr_ok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sel = OWN_INST;
    unique case (state)
      IDLE: begin
        if (data_req && !force_i) sel = OWN_DATA;
        else if (inst_req)        sel = OWN_INST;
        else if (data_req)        sel = OWN_DATA;
      end
      HOLD_I:  sel = OWN_INST;
      HOLD_D:  sel = OWN_DATA;
      default: sel = OWN_INST;
    endcase
  end

  // full is registered state, so a same-cycle pop never re-opens the port
  assign sel_req = (sel == OWN_DATA) ? data_req : inst_req;
  assign mem_req = sel_req && !full && !reset;
  assign accept  = mem_req && mem_addr_ok;

  assign inst_addr_ok = accept && (sel == OWN_INST);
  assign data_addr_ok = accept && (sel == OWN_DATA);

  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = 2'd0;
    mem_wstrb = 4'd0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (mem_req) begin
      if (sel == OWN_DATA) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        mem_wr    = inst_wr;
        mem_size  = inst_size;
        mem_wstrb = inst_wstrb;
        mem_addr  = inst_addr;
        mem_wdata = inst_wdata;
      end
    end
  end

  assign resp         = mem_data_ok && !reset;
  assign pop          = resp && !empty;
  assign inst_data_ok = pop && (head == OWN_INST);
  assign data_data_ok = pop && (head == OWN_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  owner_fifo #(
    .DEPTH(MAX_OUTSTANDING)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (accept),
    .pop  (pop),
    .din  (sel),
    .dout (head),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge clk) begin
    if (reset)
      starve_cnt <= 4'd0;
    else if (!inst_req || inst_addr_ok)
      starve_cnt <= 4'd0;
    else if (!force_i)
      starve_cnt <= starve_cnt + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset)                     err_resp <= 1'b0;
    else if (mem_data_ok && empty) err_resp <= 1'b1;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: priority, hold, full,
// starvation override, orphan responses and mid-flight reset.
module tb_sram_port_arbiter;
  import sram_port_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        err_resp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(
    .MAX_OUTSTANDING(2),
    .STARVE_LIMIT   (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .inst_req    (inst_req),
    .inst_wr     (inst_wr),
    .inst_size   (inst_size),
    .inst_wstrb  (inst_wstrb),
    .inst_addr   (inst_addr),
    .inst_wdata  (inst_wdata),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_size   (data_size),
    .data_wstrb  (data_wstrb),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata  (data_rdata),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_size    (mem_size),
    .mem_wstrb   (mem_wstrb),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok),
    .mem_rdata   (mem_rdata),
    .err_resp    (err_resp)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    reset = 1'b1;
    inst_req = 1'b1; inst_wr = 1'b0; inst_size = SIZE_WORD;
    inst_wstrb = 4'h0; inst_addr = 32'h200; inst_wdata = 32'h0;
    data_req = 1'b0; data_wr = 1'b0; data_size = SIZE_WORD;
    data_wstrb = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    mem_addr_ok = 1'b1; mem_data_ok = 1'b0; mem_rdata = 32'h0;

    // reset state
    cyc(); settle();
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_inst_aok", 32'(inst_addr_ok), 0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    chk("rst_count", 32'(dut.u_fifo.count), 0);
    chk("rst_err", 32'(err_resp), 0);
    chk("rst_starve", 32'(dut.starve_cnt), 0);

    // both request: data first, then inst
    cyc(); reset = 1'b0;
    data_req = 1'b1; data_addr = 32'h100;
    inst_req = 1'b1; inst_addr = 32'h200; settle();
    chk("prio_data_aok", 32'(data_addr_ok), 1);
    chk("prio_inst_aok", 32'(inst_addr_ok), 0);
    chk("prio_addr", mem_addr, 32'h100);
    cyc(); data_req = 1'b0; settle();
    chk("prio2_inst_aok", 32'(inst_addr_ok), 1);
    chk("prio2_addr", mem_addr, 32'h200);
    cyc(); inst_req = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'h11111111; settle();
    chk("resp1_data_ok", 32'(data_data_ok), 1);
    chk("resp1_inst_ok", 32'(inst_data_ok), 0);
    chk("resp1_rdata", data_rdata, 32'h11111111);
    cyc(); mem_rdata = 32'h22222222; settle();
    chk("resp2_inst_ok", 32'(inst_data_ok), 1);
    chk("resp2_data_ok", 32'(data_data_ok), 0);
    chk("resp2_rdata", inst_rdata, 32'h22222222);

    // data write held off for three cycles
    cyc(); mem_data_ok = 1'b0; mem_addr_ok = 1'b0;
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h300;
    data_wdata = 32'hDEADBEEF; data_wstrb = 4'hF; settle();
    chk("hold0_req", 32'(mem_req), 1);
    chk("hold0_addr", mem_addr, 32'h300);
    for (int i = 1; i < 3; i++) begin
      cyc(); inst_req = 1'b1; inst_addr = 32'h204; settle();
      chk("hold_state", 32'(dut.state), 32'(HOLD_D));
      chk("hold_addr", mem_addr, 32'h300);
      chk("hold_wdata", mem_wdata, 32'hDEADBEEF);
      chk("hold_wr", 32'(mem_wr), 1);
      chk("hold_inst_aok", 32'(inst_addr_ok), 0);
    end
    cyc(); mem_addr_ok = 1'b1; settle();
    chk("hold_rel_aok", 32'(data_addr_ok), 1);
    chk("hold_rel_addr", mem_addr, 32'h300);
    cyc(); data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0;
    settle();
    chk("after_hold_inst", 32'(inst_addr_ok), 1);
    chk("after_hold_addr", mem_addr, 32'h204);

    // full FIFO blocks new requests
    cyc(); inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h400;
    settle();
    chk("full_flag", 32'(dut.u_fifo.full), 1);
    chk("full_mem_req", 32'(mem_req), 0);
    chk("full_addr_zero", mem_addr, 0);
    chk("full_data_aok", 32'(data_addr_ok), 0);
    cyc(); mem_data_ok = 1'b1; mem_rdata = 32'hAAAA0001; settle();
    chk("fullpop_data_ok", 32'(data_data_ok), 1);
    chk("fullpop_mem_req", 32'(mem_req), 0);
    cyc(); mem_rdata = 32'hAAAA0002; settle();
    chk("pushpop_aok", 32'(data_addr_ok), 1);
    chk("pushpop_inst_ok", 32'(inst_data_ok), 1);
    cyc(); mem_data_ok = 1'b0; data_req = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h500; settle();
    chk("pushpop_count", 32'(dut.u_fifo.count), 1);
    chk("wrap_inst_aok", 32'(inst_addr_ok), 1);
    cyc(); inst_req = 1'b0; mem_data_ok = 1'b1; settle();
    chk("wrap_count", 32'(dut.u_fifo.count), 2);
    chk("wrap_data_ok", 32'(data_data_ok), 1);
    cyc(); settle();
    chk("wrap_inst_ok", 32'(inst_data_ok), 1);
    cyc(); mem_data_ok = 1'b0; settle();
    chk("drain_count", 32'(dut.u_fifo.count), 0);

    // fetch starvation override
    for (int i = 1; i <= 9; i++) begin
      cyc();
      data_req = 1'b1; data_addr = 32'h600;
      inst_req = 1'b1; inst_addr = 32'h700;
      mem_data_ok = (i > 1); settle();
      chk("starve_cnt", 32'(dut.starve_cnt), 32'(i - 1));
      chk("starve_dok", 32'(data_data_ok), 32'(i > 1));
      if (i < 9) begin
        chk("starve_data_aok", 32'(data_addr_ok), 1);
        chk("starve_inst_aok", 32'(inst_addr_ok), 0);
      end else begin
        chk("force_inst_aok", 32'(inst_addr_ok), 1);
        chk("force_data_aok", 32'(data_addr_ok), 0);
        chk("force_addr", mem_addr, 32'h700);
      end
    end
    cyc(); data_req = 1'b0; inst_req = 1'b0; mem_data_ok = 1'b1;
    settle();
    chk("starve_clear", 32'(dut.starve_cnt), 0);
    chk("force_resp_inst", 32'(inst_data_ok), 1);
    cyc(); mem_data_ok = 1'b0; settle();
    chk("starve_drain", 32'(dut.u_fifo.count), 0);
    chk("no_err_yet", 32'(err_resp), 0);

    // orphan response
    cyc(); mem_data_ok = 1'b1; settle();
    chk("orphan_dok", 32'(data_data_ok), 0);
    chk("orphan_iok", 32'(inst_data_ok), 0);
    cyc(); mem_data_ok = 1'b0; settle();
    chk("orphan_err", 32'(err_resp), 1);
    cyc(); cyc(); settle();
    chk("orphan_sticky", 32'(err_resp), 1);

    // reset with two outstanding
    cyc(); data_req = 1'b1; data_addr = 32'h800; settle();
    chk("pre_rst_daok", 32'(data_addr_ok), 1);
    cyc(); data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h900;
    settle();
    chk("pre_rst_iaok", 32'(inst_addr_ok), 1);
    cyc(); reset = 1'b1; settle();
    chk("pre_rst_count", 32'(dut.u_fifo.count), 2);
    chk("in_rst_req", 32'(mem_req), 0);
    chk("in_rst_iaok", 32'(inst_addr_ok), 0);
    cyc(); mem_data_ok = 1'b1; settle();
    chk("rst2_count", 32'(dut.u_fifo.count), 0);
    chk("rst2_err", 32'(err_resp), 0);
    chk("rst2_req", 32'(mem_req), 0);
    chk("rst2_iok", 32'(inst_data_ok), 0);
    chk("rst2_dok", 32'(data_data_ok), 0);
    cyc(); reset = 1'b0; mem_data_ok = 1'b0;
    inst_addr = 32'h904; settle();
    chk("post_rst_iaok", 32'(inst_addr_ok), 1);
    chk("post_rst_addr", mem_addr, 32'h904);
    cyc(); inst_req = 1'b0; mem_data_ok = 1'b1;
    mem_rdata = 32'h33333333; settle();
    chk("post_rst_iok", 32'(inst_data_ok), 1);
    chk("post_rst_rdata", inst_rdata, 32'h33333333);
    cyc(); mem_data_ok = 1'b0; settle();
    chk("post_rst_count", 32'(dut.u_fifo.count), 0);
    chk("post_rst_err", 32'(err_resp), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
